// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops bytes one per cycle and packs PACK of them
// into a wide word on a valid/ready stream, with a flush that emits a partial word.
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4,
   parameter int CNT_W      = $clog2(PACK+1)
) (
   input  logic                       rd_clk,
   input  logic                       rst_n,
   input  logic                       fifo_empty,
   input  logic [DATA_WIDTH-1:0]      fifo_r_data,
   output logic                       fifo_rd_en,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH*PACK-1:0] out_data,
   output logic [CNT_W-1:0]           out_bytes,
   output logic                       flush_busy,
   // {flush_req, acc_full, pend, cnt}
   output logic [CNT_W+2:0]           dbg_state
);

   localparam int               WORD_W    = DATA_WIDTH*PACK;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK-1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PACK);
   localparam logic [CNT_W:0]   PACK_EXT  = (CNT_W+1)'(PACK);

   // Handshake: a word transfers on every rd_clk edge where out_valid && out_ready;
   // while out_valid && !out_ready, out_data/out_bytes/out_valid hold stable.

   logic              pend,      pend_nxt;
   logic [CNT_W-1:0]  cnt,       cnt_nxt;
   logic [WORD_W-1:0] acc,       acc_nxt;
   logic              acc_full,  acc_full_nxt;
   logic              flush_req, flush_req_nxt;
   logic              ov_nxt;
   logic [WORD_W-1:0] od_nxt;
   logic [CNT_W-1:0]  ob_nxt;

   logic              out_free;
   logic [CNT_W:0]    fill;
   logic [WORD_W-1:0] land_word;

   assign out_free = !out_valid || out_ready;
   assign fill     = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};

   // A pop may overlap the completing landing only if that word can leave this cycle.
   assign fifo_rd_en = rst_n && !fifo_empty && !acc_full && !flush_req &&
                       ((fill < PACK_EXT) || (fill == PACK_EXT && pend && out_free));

   assign flush_busy = flush_req;
   assign dbg_state  = {flush_req, acc_full, pend, cnt};

   always_comb begin
      land_word = acc;
      for (int i = 0; i < PACK; i++) begin
         if (cnt == CNT_W'(i)) begin
            land_word[i*DATA_WIDTH +: DATA_WIDTH] = fifo_r_data;
         end
      end
   end

   always_comb begin
      pend_nxt      = fifo_rd_en;
      cnt_nxt       = cnt;
      acc_nxt       = acc;
      acc_full_nxt  = acc_full;
      flush_req_nxt = flush_req || flush;
      ov_nxt        = out_valid && !out_ready;
      od_nxt        = out_data;
      ob_nxt        = out_bytes;

      if (pend) begin
         if (cnt == LAST_LANE) begin
            if (out_free) begin
               ov_nxt  = 1'b1;
               od_nxt  = land_word;
               ob_nxt  = FULL_CNT;
               cnt_nxt = '0;
               acc_nxt = '0;
            end else begin
               acc_nxt      = land_word;
               acc_full_nxt = 1'b1;
               cnt_nxt      = FULL_CNT;
            end
         end else begin
            acc_nxt = land_word;
            cnt_nxt = cnt + CNT_W'(1);
         end
      end else if (acc_full) begin
         if (out_free) begin
            ov_nxt       = 1'b1;
            od_nxt       = acc;
            ob_nxt       = FULL_CNT;
            acc_full_nxt = 1'b0;
            cnt_nxt      = '0;
            acc_nxt      = '0;
         end
      end else if (flush_req && out_free) begin
         // Unused lanes are already zero because acc is cleared whenever a word leaves.
         if (cnt != '0) begin
            ov_nxt = 1'b1;
            od_nxt = acc;
            ob_nxt = cnt;
         end
         cnt_nxt       = '0;
         acc_nxt       = '0;
         flush_req_nxt = 1'b0;
      end
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         acc_full  <= 1'b0;
         flush_req <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_bytes <= '0;
      end else begin
         pend      <= pend_nxt;
         cnt       <= cnt_nxt;
         acc       <= acc_nxt;
         acc_full  <= acc_full_nxt;
         flush_req <= flush_req_nxt;
         out_valid <= ov_nxt;
         out_data  <= od_nxt;
         out_bytes <= ob_nxt;
      end
   end

endmodule
